sata_link_supervisor: RTL and testbench

- Sequences the SATA PHY OOB controller: owns its reset, restarts OOB after link-up timeouts or link loss, and applies exponential backoff between attempts.
- Declares permanent failure after a bounded number of retries.
- Sits between the host control/status registers and the OOB controller, in the sata clk (usrclk2) domain.
- Accepts host COMRESET requests and a link-disable control.

---
 rtl/sata_link_pkg.sv | 28 ++
 rtl/sata_link_timer.sv | 27 ++
 rtl/sata_link_supervisor.sv | 169 ++++++++++++++++
 tb/tb_sata_link_supervisor.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/sata_link_pkg.sv
// Shared types, widths and cycle-scaling helpers for the SATA link supervisor.
package sata_link_pkg;

    localparam int unsigned TIMER_W           = 32;
    localparam int unsigned STATE_W           = 3;
    localparam int unsigned RETRY_W           = 4;
    localparam int unsigned MAX_BACKOFF_SHIFT = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE      = 3'd0,
        RESET     = 3'd1,
        WAIT_LINK = 3'd2,
        LINKED    = 3'd3,
        BACKOFF   = 3'd4,
        FAILED    = 3'd5
    } link_state_e;

    // Base cycle count scaled by the clock speed grade, kept wide for range checks.
    function automatic logic [63:0] scale_cycles(input int unsigned base, input int unsigned grade);
        return 64'(base) * 64'(grade);
    endfunction

    // Timer load value that yields exactly n cycles before expiry.
    function automatic logic [TIMER_W-1:0] count_load(input logic [63:0] n);
        return (n == 64'd0) ? '0 : TIMER_W'(n - 64'd1);
    endfunction

endpackage

// File: rtl/sata_link_timer.sv
// Loadable down-counter shared by the reset, link-up timeout and backoff phases.
module sata_link_timer
    import sata_link_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [TIMER_W-1:0] value,
    output logic               expired_c
);

    logic [TIMER_W-1:0] cnt_q;

    // Counts down to zero and holds there; a load always takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= value;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - TIMER_W'(1);
        end
    end

    assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/sata_link_supervisor.sv
// Sequences OOB controller reset, link-up detection, retry with exponential backoff
// and permanent failure, under host COMRESET and link-disable control.
module sata_link_supervisor
    import sata_link_pkg::*;
#(
    parameter int unsigned CLK_SPEED_GRADE = 1,
    parameter int unsigned OOB_RST_CYCLES  = 16,
    parameter int unsigned LINKUP_TIMEOUT  = 65536,
    parameter int unsigned STABLE_CYCLES   = 32,
    parameter int unsigned BACKOFF_BASE    = 1024,
    parameter int unsigned RETRY_MAX       = 8
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 gtx_ready,
    input  logic                 phy_ready,
    input  logic                 link_disable,
    input  logic                 comreset_req,
    output logic                 oob_rst,
    output logic                 link_ok,
    output logic                 link_failed,
    output logic                 link_lost,
    output logic [RETRY_W-1:0]   retry_cnt,
    output logic [STATE_W-1:0]   state
);

    localparam logic [63:0] RST_N64 = scale_cycles(OOB_RST_CYCLES, CLK_SPEED_GRADE);
    localparam logic [63:0] TMO_N64 = scale_cycles(LINKUP_TIMEOUT, CLK_SPEED_GRADE);
    localparam logic [63:0] STB_N64 = scale_cycles(STABLE_CYCLES, CLK_SPEED_GRADE);
    localparam logic [63:0] BO_N64  = scale_cycles(BACKOFF_BASE, CLK_SPEED_GRADE);
    localparam logic [63:0] LIMIT32 = 64'h0000_0000_FFFF_FFFF;

    localparam logic [TIMER_W-1:0] RST_LOAD = count_load(RST_N64);
    localparam logic [TIMER_W-1:0] TMO_LOAD = count_load(TMO_N64);
    localparam logic [TIMER_W-1:0] STB_LIM  = TIMER_W'(STB_N64);
    localparam logic [TIMER_W-1:0] BO_BASE  = TIMER_W'(BO_N64);

    // Scaled counts, including the largest backoff, must fit the 32-bit timer.
    if (RST_N64 > LIMIT32 || TMO_N64 > LIMIT32 || STB_N64 > LIMIT32 ||
        (BO_N64 << MAX_BACKOFF_SHIFT) > LIMIT32) begin : g_width_check
        $error("sata_link_supervisor: scaled cycle counts exceed 32 bits");
    end

    if (RETRY_MAX == 0 || RETRY_MAX > 15) begin : g_retry_check
        $error("sata_link_supervisor: RETRY_MAX must be in 1..15");
    end

    link_state_e         state_q, state_d;
    logic [RETRY_W-1:0]  retry_q, retry_d, retry_inc, retry_m1;
    logic [TIMER_W-1:0]  stable_q, stable_d;
    logic [TIMER_W-1:0]  tmr_val, bo_len;
    logic [2:0]          bo_shift;
    logic                stable_hit, lost_d, restart, tmr_load, tmr_expired;

    sata_link_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (tmr_load),
        .value     (tmr_val),
        .expired_c (tmr_expired)
    );

    // Next-state, retry accounting and timer reload selection.
    always_comb begin
        state_d    = state_q;
        retry_d    = retry_q;
        lost_d     = 1'b0;
        restart    = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        bo_shift   = '0;
        bo_len     = '0;
        retry_m1   = '0;
        stable_d   = '0;
        retry_inc  = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;

        if (state_q == WAIT_LINK && phy_ready) begin
            stable_d = (stable_q == STB_LIM) ? stable_q : stable_q + TIMER_W'(1);
        end
        stable_hit = (state_q == WAIT_LINK) && phy_ready && (stable_d >= STB_LIM);

        case (state_q)
            IDLE: begin
                if (gtx_ready && !link_disable) state_d = RESET;
            end
            RESET: begin
                if (tmr_expired) state_d = WAIT_LINK;
            end
            WAIT_LINK: begin
                // A link that becomes stable on the timeout cycle still counts as up.
                if (stable_hit) begin
                    state_d = LINKED;
                    retry_d = '0;
                end else if (tmr_expired) begin
                    retry_d = retry_inc;
                    state_d = (32'(retry_inc) >= RETRY_MAX) ? FAILED : BACKOFF;
                end
            end
            LINKED: begin
                if (!phy_ready) begin
                    lost_d  = 1'b1;
                    retry_d = retry_inc;
                    state_d = BACKOFF;
                end
            end
            BACKOFF: begin
                if (tmr_expired) state_d = RESET;
            end
            FAILED: begin
                state_d = FAILED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Host overrides; losing the GTX or disabling the link beats COMRESET.
        if (state_q != IDLE) begin
            if (!gtx_ready || link_disable) begin
                state_d = IDLE;
                retry_d = retry_q;
                lost_d  = 1'b0;
            end else if (comreset_req) begin
                state_d = RESET;
                retry_d = '0;
                lost_d  = 1'b0;
                restart = 1'b1;
            end
        end

        tmr_load = (state_d != state_q) || restart;
        retry_m1 = (retry_d == '0) ? '0 : retry_d - 4'd1;
        bo_shift = (retry_m1 > 4'(MAX_BACKOFF_SHIFT)) ? 3'(MAX_BACKOFF_SHIFT) : 3'(retry_m1);
        bo_len   = BO_BASE << bo_shift;

        case (state_d)
            RESET:     tmr_val = RST_LOAD;
            WAIT_LINK: tmr_val = TMO_LOAD;
            BACKOFF:   tmr_val = (bo_len == '0) ? '0 : bo_len - TIMER_W'(1);
            default:   tmr_val = '0;
        endcase
    end

    // State, counters and registered status outputs aligned to the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            retry_q     <= '0;
            stable_q    <= '0;
            oob_rst     <= 1'b1;
            link_ok     <= 1'b0;
            link_failed <= 1'b0;
            link_lost   <= 1'b0;
        end else begin
            state_q     <= state_d;
            retry_q     <= retry_d;
            stable_q    <= stable_d;
            oob_rst     <= !(state_d == WAIT_LINK || state_d == LINKED);
            link_ok     <= (state_d == LINKED);
            link_failed <= (state_d == FAILED);
            link_lost   <= lost_d;
        end
    end

    assign state     = state_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_sata_link_supervisor.sv
// Directed table-driven bench for sata_link_supervisor with small cycle parameters.
module tb_sata_link_supervisor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       gtx_ready = 1'b0;
    logic       phy_ready = 1'b0;
    logic       link_disable = 1'b0;
    logic       comreset_req = 1'b0;
    logic       oob_rst, link_ok, link_failed, link_lost;
    logic [3:0] retry_cnt;
    logic [2:0] state;

    int tests  = 0;
    int errors = 0;

    typedef struct {
        logic       r, g, p, d, c;
        int         n;
        logic [2:0] st;
        logic       oob, ok, fail, lost;
        logic [3:0] rc;
    } vec_t;

    vec_t vecs [64];
    int   nvec = 0;

    sata_link_supervisor #(
        .CLK_SPEED_GRADE (1),
        .OOB_RST_CYCLES  (4),
        .LINKUP_TIMEOUT  (100),
        .STABLE_CYCLES   (8),
        .BACKOFF_BASE    (10),
        .RETRY_MAX       (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .gtx_ready    (gtx_ready),
        .phy_ready    (phy_ready),
        .link_disable (link_disable),
        .comreset_req (comreset_req),
        .oob_rst      (oob_rst),
        .link_ok      (link_ok),
        .link_failed  (link_failed),
        .link_lost    (link_lost),
        .retry_cnt    (retry_cnt),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [2:0] st, input logic oob,
                         input logic ok, input logic fail, input logic lost, input logic [3:0] rc);
        tests++;
        if ({state, oob_rst, link_ok, link_failed, link_lost, retry_cnt} !==
            {st, oob, ok, fail, lost, rc}) begin
            errors++;
            $display("FAIL %s: got state=%0d oob_rst=%b link_ok=%b link_failed=%b link_lost=%b retry_cnt=%0d, expected state=%0d oob_rst=%b link_ok=%b link_failed=%b link_lost=%b retry_cnt=%0d",
                     name, state, oob_rst, link_ok, link_failed, link_lost, retry_cnt,
                     st, oob, ok, fail, lost, rc);
        end
    endtask

    task automatic add(input logic r, input logic g, input logic p, input logic d, input logic c,
                       input int n, input logic [2:0] st, input logic oob, input logic ok,
                       input logic fail, input logic lost, input logic [3:0] rc);
        vecs[nvec].r = r;   vecs[nvec].g = g;     vecs[nvec].p = p;
        vecs[nvec].d = d;   vecs[nvec].c = c;     vecs[nvec].n = n;
        vecs[nvec].st = st; vecs[nvec].oob = oob; vecs[nvec].ok = ok;
        vecs[nvec].fail = fail; vecs[nvec].lost = lost; vecs[nvec].rc = rc;
        nvec++;
    endtask

    initial begin
        //   r  g  p  d  c   n    st oob ok fl ls rc
        add(1, 0, 0, 0, 0,   2,   0, 1, 0, 0, 0, 0);  // reset state
        add(0, 1, 0, 0, 0,   1,   1, 1, 0, 0, 0, 0);  // RESET entry
        add(0, 1, 0, 0, 0,   3,   1, 1, 0, 0, 0, 0);  // 4th RESET cycle
        add(0, 1, 0, 0, 0,   1,   2, 0, 0, 0, 0, 0);  // WAIT_LINK, oob released
        add(0, 1, 0, 0, 0,  19,   2, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0,   7,   2, 0, 0, 0, 0, 0);  // 7 stable cycles: not yet
        add(0, 1, 1, 0, 0,   1,   3, 0, 1, 0, 0, 0);  // 8th: LINKED
        add(0, 1, 0, 0, 0,   1,   4, 1, 0, 0, 1, 1);  // link loss pulse
        add(0, 1, 0, 0, 0,   9,   4, 1, 0, 0, 0, 1);  // 10th BACKOFF cycle
        add(0, 1, 0, 0, 0,   1,   1, 1, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0,   2,   1, 1, 0, 0, 0, 1);
        add(0, 1, 0, 0, 1,   1,   1, 1, 0, 0, 0, 0);  // COMRESET mid-RESET restarts pulse
        add(0, 1, 0, 0, 0,   3,   1, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0,   1,   2, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0,  98,   2, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0,   1,   2, 0, 0, 0, 0, 0);  // 100th WAIT_LINK cycle
        add(0, 1, 0, 0, 0,   1,   4, 1, 0, 0, 0, 1);  // timeout 1
        add(0, 1, 0, 0, 0,   9,   4, 1, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0,   1,   1, 1, 0, 0, 0, 1);  // backoff of 10
        add(0, 1, 0, 0, 0,   3,   1, 1, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0,   1,   2, 0, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0,  99,   2, 0, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0,   1,   4, 1, 0, 0, 0, 2);  // timeout 2
        add(0, 1, 0, 0, 0,  19,   4, 1, 0, 0, 0, 2);
        add(0, 1, 0, 0, 0,   1,   1, 1, 0, 0, 0, 2);  // backoff of 20
        add(0, 1, 0, 0, 0,   3,   1, 1, 0, 0, 0, 2);
        add(0, 1, 0, 0, 0,   1,   2, 0, 0, 0, 0, 2);
        add(0, 1, 0, 0, 0,  99,   2, 0, 0, 0, 0, 2);
        add(0, 1, 0, 0, 0,   1,   5, 1, 0, 1, 0, 3);  // timeout 3: FAILED
        add(0, 1, 0, 0, 0,  50,   5, 1, 0, 1, 0, 3);  // FAILED is held
        add(0, 1, 0, 1, 1,   1,   0, 1, 0, 0, 0, 3);  // disable beats COMRESET
        add(0, 1, 0, 1, 1,   3,   0, 1, 0, 0, 0, 3);  // COMRESET ignored in IDLE
        add(0, 1, 0, 0, 0,   1,   1, 1, 0, 0, 0, 3);
        add(0, 1, 0, 0, 0,   3,   1, 1, 0, 0, 0, 3);
        add(0, 1, 0, 0, 0,   1,   2, 0, 0, 0, 0, 3);
        add(0, 1, 0, 0, 0,  99,   2, 0, 0, 0, 0, 3);
        add(0, 1, 0, 0, 0,   1,   5, 1, 0, 1, 0, 4);  // FAILED again
        add(0, 1, 0, 0, 1,   1,   1, 1, 0, 0, 0, 0);  // COMRESET recovers from FAILED
        add(0, 1, 0, 0, 0,   3,   1, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0,   1,   2, 0, 0, 0, 0, 0);

        for (int i = 0; i < nvec; i++) begin
            rst = vecs[i].r; gtx_ready = vecs[i].g; phy_ready = vecs[i].p;
            link_disable = vecs[i].d; comreset_req = vecs[i].c;
            tick(1);
            comreset_req = 1'b0;
            tick(vecs[i].n - 1);
            check($sformatf("vec%0d", i), vecs[i].st, vecs[i].oob, vecs[i].ok,
                  vecs[i].fail, vecs[i].lost, vecs[i].rc);
        end

        // Glitch in phy_ready restarts the stable run.
        phy_ready = 1'b1; tick(7); check("glitch_run1", 2, 0, 0, 0, 0, 0);
        phy_ready = 1'b0; tick(1); check("glitch_low", 2, 0, 0, 0, 0, 0);
        phy_ready = 1'b1; tick(7); check("glitch_run2_7", 2, 0, 0, 0, 0, 0);
        tick(1); check("glitch_linked", 3, 0, 1, 0, 0, 0);

        // GTX drop in LINKED: straight to IDLE, no link_lost pulse.
        gtx_ready = 1'b0; tick(1); check("gtx_drop_linked", 0, 1, 0, 0, 0, 0);

        // Stable condition on the timeout cycle wins.
        gtx_ready = 1'b1; phy_ready = 1'b0; tick(4); tick(1);
        check("tie_wait_entry", 2, 0, 0, 0, 0, 0);
        tick(84); phy_ready = 1'b1; tick(7); phy_ready = 1'b0; tick(1);
        phy_ready = 1'b1; tick(7); check("tie_before", 2, 0, 0, 0, 0, 0);
        tick(1); check("tie_stable_wins", 3, 0, 1, 0, 0, 0);

        // Glitch must not restart the link-up timeout.
        gtx_ready = 1'b0; tick(1);
        gtx_ready = 1'b1; phy_ready = 1'b0; tick(5);
        check("tmo_wait_entry", 2, 0, 0, 0, 0, 0);
        tick(85); phy_ready = 1'b1; tick(7); phy_ready = 1'b0; tick(1);
        phy_ready = 1'b1; tick(6); check("tmo_before", 2, 0, 0, 0, 0, 0);
        tick(1); check("glitch_no_timer_reset", 4, 1, 0, 0, 0, 1);

        // Mid-operation synchronous reset.
        phy_ready = 1'b0; tick(2); check("in_backoff", 4, 1, 0, 0, 0, 1);
        rst = 1'b1; tick(1); check("rst_in_backoff", 0, 1, 0, 0, 0, 0);
        rst = 1'b0; tick(5); check("rewait_entry", 2, 0, 0, 0, 0, 0);
        tick(5);
        rst = 1'b1; tick(1); check("rst_in_wait_link", 0, 1, 0, 0, 0, 0);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
